// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Two-stage execute pipeline around an external combinational 16-bit Hack ALU.
//   Stage 1 registers a decoded instruction and drives the ALU operand/control
//   pins. Stage 2 captures the ALU result and flags, resolves the destination
//   enables and jump decision, and presents the result to writeback.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_instr, in_d, in_a, in_m operands
//   flush                 discards every in-flight entry (head may still retire)
//   alu_x/alu_y/alu_ctrl  registered operands and {zx,nx,zy,ny,f,no} to the ALU
//   alu_out/alu_zr/alu_ng combinational ALU return
//   out_valid/out_ready   writeback handshake
//   out_result/out_dest/out_jump/out_zr/out_ng  registered stage 2 results
//   ret_count             retired-instruction counter, wraps at 2^COUNT_W
module alu_exec_stage #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_instr,
  input  logic [WIDTH-1:0]   in_d,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_m,
  input  logic               flush,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  output logic [5:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_zr,
  input  logic               alu_ng,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [2:0]         out_dest,
  output logic               out_jump,
  output logic               out_zr,
  output logic               out_ng,
  output logic [COUNT_W-1:0] ret_count
);

  logic        s1_valid_r;
  logic        s2_valid_r;
  logic [15:0] s1_instr_r;

  logic        adv2_s;
  logic        accept_s;
  logic        load2_s;
  logic        retire_s;

  logic [WIDTH-1:0] nxt_result_s;
  logic [2:0]       nxt_dest_s;
  logic             nxt_jump_s;
  logic             nxt_zr_s;
  logic             nxt_ng_s;

  // Jump condition from the {lt,eq,gt} bits and the result flags.
  function automatic logic jump_decide(input logic [2:0] jbits,
                                       input logic zr, input logic ng);
    jump_decide = (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~ng & ~zr);
  endfunction

  // Stage 2 can take a new entry when it is empty or its entry leaves now.
  assign adv2_s    = ~s2_valid_r | out_ready;
  assign in_ready  = ~s1_valid_r | adv2_s;
  // Flush suppresses both the accept and the stage 1 -> stage 2 move even
  // though in_ready may read 1 on that cycle.
  assign accept_s  = in_valid & in_ready & ~flush;
  assign load2_s   = s1_valid_r & adv2_s & ~flush;
  assign retire_s  = s2_valid_r & out_ready;
  assign out_valid = s2_valid_r;

  // Stage 2 next-value decode for C- and A-instructions.
  always_comb begin
    nxt_result_s = '0;
    nxt_dest_s   = 3'b000;
    nxt_jump_s   = 1'b0;
    nxt_zr_s     = 1'b0;
    nxt_ng_s     = 1'b0;
    if (s1_instr_r[15]) begin
      nxt_result_s = alu_out;
      nxt_zr_s     = alu_zr;
      nxt_ng_s     = alu_ng;
      nxt_dest_s   = s1_instr_r[5:3];
      nxt_jump_s   = jump_decide(s1_instr_r[2:0], alu_zr, alu_ng);
    end else begin
      // A-instruction: the constant is zero-extended, so it is never negative.
      nxt_result_s[14:0] = s1_instr_r[14:0];
      nxt_zr_s           = (s1_instr_r[14:0] == 15'd0);
      nxt_ng_s           = 1'b0;
      nxt_dest_s         = 3'b100;
      nxt_jump_s         = 1'b0;
    end
  end

  // Stage 1: accept an instruction and drive the ALU operand/control pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_instr_r <= 16'd0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_ctrl   <= 6'd0;
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (adv2_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (accept_s) begin
        s1_instr_r <= in_instr;
        alu_x      <= in_d;
        alu_y      <= in_instr[12] ? in_m : in_a;
        alu_ctrl   <= in_instr[15] ? in_instr[11:6] : 6'd0;
      end
    end
  end

  // Stage 2: capture the result, flags, destination and jump decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      out_result <= '0;
      out_dest   <= 3'b000;
      out_jump   <= 1'b0;
      out_zr     <= 1'b0;
      out_ng     <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid_r <= 1'b0;
      end else if (load2_s) begin
        s2_valid_r <= 1'b1;
      end else if (out_ready) begin
        s2_valid_r <= 1'b0;
      end else begin
        s2_valid_r <= s2_valid_r;
      end
      if (load2_s) begin
        out_result <= nxt_result_s;
        out_dest   <= nxt_dest_s;
        out_jump   <= nxt_jump_s;
        out_zr     <= nxt_zr_s;
        out_ng     <= nxt_ng_s;
      end
    end
  end

  // Retired-instruction counter; a handshake on a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ret_count <= '0;
    end else if (retire_s) begin
      ret_count <= ret_count + COUNT_W'(1);
    end else begin
      ret_count <= ret_count;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr, in_d, in_a, in_m;
  logic        flush;
  logic [15:0] alu_x, alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic        out_jump, out_zr, out_ng;
  logic [3:0]  ret_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] result;
    logic [2:0]  dest;
    logic        jump;
    logic        zr;
    logic        ng;
    int          acc;
  } entry_t;

  entry_t     q[$];
  entry_t     ret_log[$];
  logic [3:0] ret_m = 4'd0;
  bit         live = 1'b0;
  bit         rst_seen = 1'b0;
  int         cyc = 0;

  alu_exec_stage #(.WIDTH(16), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_d(in_d), .in_a(in_a), .in_m(in_m), .flush(flush),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_jump(out_jump),
    .out_zr(out_zr), .out_ng(out_ng), .ret_count(ret_count)
  );

  always #5 clk = ~clk;

  // Hack ALU behaviour
  function automatic logic [15:0] hack_alu(input logic [15:0] x0, input logic [15:0] y0,
                                           input logic [5:0] c);
    logic [15:0] x, y, o;
    x = c[5] ? 16'd0 : x0;
    if (c[4]) x = ~x;
    y = c[3] ? 16'd0 : y0;
    if (c[2]) y = ~y;
    o = c[1] ? (x + y) : (x & y);
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
    alu_zr  = (alu_out == 16'd0);
    alu_ng  = alu_out[15];
  end

  // What an instruction must produce, from its meaning
  function automatic entry_t predict(input logic [15:0] ins, input logic [15:0] d,
                                     input logic [15:0] a, input logic [15:0] m, input int acc);
    entry_t e;
    if (!ins[15]) begin
      e.result = {1'b0, ins[14:0]};
      e.dest   = 3'b100;
      e.jump   = 1'b0;
    end else begin
      e.result = hack_alu(d, ins[12] ? m : a, ins[11:6]);
      e.dest   = ins[5:3];
      e.jump   = (ins[2] && $signed(e.result) < 0) || (ins[1] && e.result == 16'd0) ||
                 (ins[0] && $signed(e.result) > 0);
    end
    e.zr  = (e.result == 16'd0);
    e.ng  = e.result[15];
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare DUT against the model, then advance the model for the next edge
  always @(negedge clk) begin
    bit exp_valid;
    bit exp_ready;
    exp_valid = (q.size() > 0) && (q[0].acc + 1 < cyc);
    exp_ready = (q.size() < 2) || (out_ready == 1'b1);
    if (live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("ret_count", {28'd0, ret_count}, {28'd0, ret_m});
      if (exp_valid && out_valid) begin
        chk("out_result", {16'd0, out_result}, {16'd0, q[0].result});
        chk("out_dest", {29'd0, out_dest}, {29'd0, q[0].dest});
        chk("out_jump", {31'd0, out_jump}, {31'd0, q[0].jump});
        chk("out_zr", {31'd0, out_zr}, {31'd0, q[0].zr});
        chk("out_ng", {31'd0, out_ng}, {31'd0, q[0].ng});
      end
      if (rst_seen) begin
        chk("reset_outputs",
            {out_result, 10'd0, out_dest, out_jump, out_zr, out_ng}, 32'd0);
        chk("reset_alu_pins", {alu_x, alu_y}, 32'd0);
        chk("reset_alu_ctrl", {26'd0, alu_ctrl}, 32'd0);
      end
    end
    rst_seen = 1'b0;
    if (!rst_n) begin
      q.delete();
      ret_m    = 4'd0;
      live     = 1'b1;
      rst_seen = 1'b1;
    end else if (live) begin
      if (out_valid && out_ready) begin
        entry_t r;
        r.result = out_result; r.dest = out_dest; r.jump = out_jump;
        r.zr = out_zr; r.ng = out_ng; r.acc = cyc;
        ret_log.push_back(r);
      end
      if (exp_valid && out_ready) begin
        void'(q.pop_front());
        ret_m = ret_m + 4'd1;
      end
      if (flush) q.delete();
      else if (in_valid && exp_ready) q.push_back(predict(in_instr, in_d, in_a, in_m, cyc));
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic send_one(input logic [15:0] ins, input logic [15:0] d,
                          input logic [15:0] a, input logic [15:0] m);
    in_valid = 1'b1; in_instr = ins; in_d = d; in_a = a; in_m = m;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] t4_ins [4] = '{16'h0044, 16'hF090, 16'h0033, 16'hE394};
    logic [15:0] t4_d   [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0005};
    logic [15:0] t4_res [4] = '{16'h0044, 16'h0011, 16'h0033, 16'h0004};
    logic [2:0]  t4_dst [4] = '{3'b100, 3'b010, 3'b100, 3'b010};
    int base, sent, n;
    logic [3:0] rc;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 16'd0; in_d = 16'd0; in_a = 16'd0; in_m = 16'd0;
    do_reset();
    chk("t0_in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // 1: A-instruction, two-cycle latency
    in_valid = 1'b1; in_instr = 16'h0005;
    step();
    chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    step();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_result", {16'd0, out_result}, 32'h0005);
    chk("t1_dest", {29'd0, out_dest}, 32'd4);
    chk("t1_jump", {31'd0, out_jump}, 32'd0);

    // 2: D=D+A
    send_one(16'hE090, 16'h0003, 16'h0004, 16'hBEEF);
    chk("t2_result", {16'd0, out_result}, 32'h0007);
    chk("t2_flags", {29'd0, out_dest, out_zr, out_ng, out_jump} >> 0, {24'd0, 3'b010, 3'b000} >> 0);

    // 3: D=D-1;JLT
    send_one(16'hE394, 16'h0000, 16'h1111, 16'h2222);
    chk("t3a_result", {16'd0, out_result}, 32'hFFFF);
    chk("t3a_ng_jump", {30'd0, out_ng, out_jump}, 32'd3);
    send_one(16'hE394, 16'h0001, 16'h1111, 16'h2222);
    chk("t3b_result", {16'd0, out_result}, 32'h0000);
    chk("t3b_zr_jump", {30'd0, out_zr, out_jump}, 32'd2);

    // 4: back-to-back stream with 3 cycles of backpressure
    do_reset();
    base = ret_log.size();
    sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 30 && sent < 4; c++) begin
      out_ready = (c >= 3);
      in_valid = 1'b1; in_instr = t4_ins[sent]; in_d = t4_d[sent];
      in_a = 16'h0002; in_m = 16'h0010;
      #1;
      if (c == 2) chk("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
      if (in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t4_sent", sent, 32'd4);
    step(); step(); step();
    chk("t4_ret_count", {28'd0, ret_count}, 32'd4);
    chk("t4_log_size", ret_log.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < ret_log.size()) begin
        chk("t4_order_result", {16'd0, ret_log[base+i].result}, {16'd0, t4_res[i]});
        chk("t4_order_dest", {29'd0, ret_log[base+i].dest}, {29'd0, t4_dst[i]});
      end
    end

    // 5: flush with both stages full while the head retires
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0101;
    step();
    in_instr = 16'h0202;
    step();
    in_instr = 16'h0303; flush = 1'b1; out_ready = 1'b1;
    rc = ret_count;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_ret_count", {28'd0, ret_count}, {28'd0, rc + 4'd1});
    chk("t5_valid_cleared", {31'd0, out_valid}, 32'd0);
    n = ret_log.size();
    chk("t5_head_retired", {16'd0, ret_log[n-1].result}, 32'h0101);
    step(); step(); step();
    chk("t5_still_empty", {31'd0, out_valid}, 32'd0);
    chk("t5_no_dropped_retire", ret_log.size(), n);

    // 6: counter wrap with COUNT_W=4, then reset mid-stream
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_instr = 16'(i + 1);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t6_wrap", {28'd0, ret_count}, 32'd1);
    in_valid = 1'b1; in_instr = 16'hE090; in_d = 16'h1234; in_a = 16'h0001;
    out_ready = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_result", {16'd0, out_result}, 32'd0);
    chk("t6_rst_misc", {26'd0, out_dest, out_jump, out_zr, out_ng}, 32'd0);
    chk("t6_rst_alu", {alu_x, alu_y}, 32'd0);
    chk("t6_rst_ctrl_cnt", {22'd0, alu_ctrl, ret_count}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
